env_emulator: RTL and testbench
===============================

ENV_EMULATOR -- requirements
Module: env_emulator

Interface
REQ-001 SHALL have parameter FG_PERIOD_CYC, default 2000000, fast-gate period in clocks (10 ms at 200 MHz).
REQ-002 SHALL have parameter FG_OPEN_CYC, default 20000, fast-gate high time in clocks (100 us).
REQ-003 SHALL have parameter FG_COUNT, default 10, number of fast-gate periods per run; 0 = free-running.
REQ-004 SHALL have parameter START_DELAY_CYC, default 5000000, clocks from run start to start_signal rise (25 ms).
REQ-005 SHALL have parameter START_WIDTH_CYC, default 20000, start_signal high time in clocks (100 us).
REQ-006 SHALL have parameter BUSY_CYC, default 1280000, detector dead time in clocks (6.4 ms).
REQ-007 clock  in  1  single system clock, all logic on rising edge.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 enable  in  1  level; high runs the emulated experiment, low stops it.
REQ-010 fg_signal  out  1  emulated fast-gate waveform.
REQ-011 start_signal  out  1  emulated start-condition pulse.
REQ-012 detector_trigger  in  1  trigger from the synchronization FSM, same clock domain.
REQ-013 detector_ready  out  1  high = detector idle; low = detector busy.
REQ-014 overrun  out  1  sticky; trigger rising edge received while detector busy.
REQ-015 fg_done  out  1  high once FG_COUNT periods have completed; stays high until enable falls.

Function
REQ-016 Fast-gate FSM states SHALL be IDLE, PHASE, LOW, HIGH, DONE.
REQ-017 IDLE->PHASE on first clock with enable high; PHASE lasts the phase offset (REQ-031/032), then ->LOW.
REQ-018 LOW SHALL hold fg_signal=0 for FG_PERIOD_CYC-FG_OPEN_CYC clocks, then ->HIGH.
REQ-019 HIGH SHALL hold fg_signal=1 for exactly FG_OPEN_CYC clocks, then increment period count.
REQ-020 After HIGH: ->DONE if FG_COUNT!=0 and count==FG_COUNT, else ->LOW; period count SHALL be wide enough for FG_COUNT without wrap.
REQ-021 Start counter SHALL begin with the IDLE->PHASE transition; start_signal high for START_WIDTH_CYC clocks beginning START_DELAY_CYC clocks after it; exactly once per enable assertion.
REQ-022 enable low in any state SHALL return FSM and start counter to IDLE next clock, fg_signal=0, start_signal=0, fg_done=0.
REQ-023 Detector: registered rising-edge detect of detector_trigger; detector_ready SHALL fall on the clock after the edge is registered (2 clocks after trigger rises) and stay low for exactly BUSY_CYC clocks.
REQ-024 Trigger edge while detector_ready=0 SHALL NOT extend or restart busy time and SHALL set overrun.
REQ-025 Trigger edge coinciding with the final busy clock SHALL count as overrun, not a new busy window.
REQ-026 Detector emulation SHALL run independently of enable.
REQ-027 overrun SHALL clear only on reset or on enable rising edge.
REQ-028 All outputs SHALL be registered; no combinational input-to-output paths.

Reset
REQ-029 reset low SHALL asynchronously force: FSM=IDLE, all counters 0, fg_signal=0, start_signal=0, detector_ready=1, overrun=0, fg_done=0.
REQ-030 Reset mid-pulse or mid-busy SHALL abort it; after reset release, operation restarts from IDLE on the first clock with enable high.

Configuration
REQ-031 With ENV_EMULATOR_JITTER_EN defined: PHASE length SHALL be a 24-bit free-running LFSR value (non-zero seed, advancing every clock since reset) sampled at IDLE->PHASE, taken modulo FG_PERIOD_CYC.
REQ-032 Without ENV_EMULATOR_JITTER_EN: PHASE length SHALL be 0 clocks (LOW entered directly), giving a deterministic waveform.

Verification (macro undefined; FG_PERIOD_CYC=100, FG_OPEN_CYC=10, FG_COUNT=3, START_DELAY_CYC=250, START_WIDTH_CYC=20, BUSY_CYC=64)
REQ-033 Reset release, enable=1 at cycle 0 -> fg_signal high cycles 90-99, 190-199, 290-299; fg_done=1 from cycle 300; no further pulses.
REQ-034 Same run -> start_signal high exactly cycles 250-269, once; re-asserting enable after low gives one new pulse.
REQ-035 detector_trigger 0->1 at cycle 10 -> detector_ready low cycles 12-75, high at 76; overrun=0.
REQ-036 Second trigger edge at cycle 40 (busy) -> overrun=1, ready still returns high at 76; trigger at cycle 75 -> overrun=1, no new window.
REQ-037 enable dropped at cycle 195 (fg high) -> fg_signal=0 at 196, FSM IDLE; reset low at cycle 30 of busy window -> detector_ready=1 immediately.
REQ-038 Macro defined, 20 runs -> first fg rise offset varies across runs, always in [90,189], period and width unchanged.

Source files
------------

// File: rtl/env_emulator.sv
// Experiment environment emulator: fast-gate train, start pulse, detector dead time.
// Optional phase jitter on the first gate is enabled by defining ENV_EMULATOR_JITTER_EN.
module env_emulator #(
  parameter int FG_PERIOD_CYC   = 2000000,
  parameter int FG_OPEN_CYC     = 20000,
  parameter int FG_COUNT        = 10,
  parameter int START_DELAY_CYC = 5000000,
  parameter int START_WIDTH_CYC = 20000,
  parameter int BUSY_CYC        = 1280000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic detector_trigger,
  output logic fg_signal,
  output logic start_signal,
  output logic detector_ready,
  output logic overrun,
  output logic fg_done
);

  localparam int PW = (FG_COUNT < 2) ? 1 : $clog2(FG_COUNT + 1);
  localparam logic [31:0] LOW_LEN = 32'(FG_PERIOD_CYC - FG_OPEN_CYC);
  localparam logic [31:0] OPEN    = 32'(FG_OPEN_CYC);
  localparam logic [31:0] S_BEG   = 32'(START_DELAY_CYC);
  localparam logic [31:0] S_END   = 32'(START_DELAY_CYC + START_WIDTH_CYC);
  localparam logic [31:0] BUSY_M1 = 32'(BUSY_CYC - 1);
  localparam logic [PW-1:0] LAST  = PW'(FG_COUNT - 1);

  typedef enum logic [2:0] {IDLE, PHASE, LOW, HIGH, DONE} state_t;

  state_t      state, state_n;
  logic [31:0] cnt, cnt_n;
  logic [31:0] plen, plen_n;
  logic [31:0] scnt, scnt_n;
  logic [PW-1:0] pcnt, pcnt_n;
  logic [31:0] phase_len;

`ifdef ENV_EMULATOR_JITTER_EN
  logic [23:0] lfsr;

  // free-running LFSR, sampled when a run begins
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) lfsr <= 24'h000001;
    else        lfsr <= {lfsr[22:0], lfsr[23] ^ lfsr[22] ^ lfsr[21] ^ lfsr[16]};
  end

  assign phase_len = {8'd0, lfsr} % 32'(FG_PERIOD_CYC);
`else
  assign phase_len = '0;
`endif

  // fast-gate and start-pulse state registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      plen         <= '0;
      scnt         <= '0;
      pcnt         <= '0;
      fg_signal    <= 1'b0;
      start_signal <= 1'b0;
      fg_done      <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      plen         <= plen_n;
      scnt         <= scnt_n;
      pcnt         <= pcnt_n;
      fg_signal    <= (state_n == HIGH);
      fg_done      <= (state_n == DONE);
      start_signal <= enable && (scnt_n >= S_BEG) && (scnt_n < S_END);
    end
  end

  // next-state: gate sequencing and start counter
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 32'd1;
    plen_n  = plen;
    pcnt_n  = pcnt;
    scnt_n  = scnt;
    if (!enable) begin
      state_n = IDLE;
      cnt_n   = '0;
      pcnt_n  = '0;
      scnt_n  = '0;
    end else begin
      if (state == IDLE)     scnt_n = '0;
      else if (scnt < S_END) scnt_n = scnt + 32'd1;
      unique case (state)
        IDLE: begin
          cnt_n   = '0;
          pcnt_n  = '0;
          plen_n  = phase_len;
          state_n = (phase_len == 32'd0) ? LOW : PHASE;
        end
        PHASE: begin
          if (cnt == plen - 32'd1) begin
            state_n = LOW;
            cnt_n   = '0;
          end
        end
        LOW: begin
          if (cnt == LOW_LEN - 32'd1) begin
            state_n = HIGH;
            cnt_n   = '0;
          end
        end
        HIGH: begin
          if (cnt == OPEN - 32'd1) begin
            cnt_n = '0;
            if (FG_COUNT != 0 && pcnt == LAST) begin
              state_n = DONE;
            end else begin
              state_n = LOW;
              if (FG_COUNT != 0) pcnt_n = pcnt + PW'(1);
            end
          end
        end
        DONE:    cnt_n = cnt;
        default: state_n = IDLE;
      endcase
    end
  end

  logic        trig_q, trig_qq, edge_q, en_q;
  logic        raw_edge;
  logic [31:0] bcnt;

  assign raw_edge = trig_q & ~trig_qq;

  // detector dead-time emulation, independent of enable
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      trig_q         <= 1'b0;
      trig_qq        <= 1'b0;
      edge_q         <= 1'b0;
      en_q           <= 1'b0;
      bcnt           <= '0;
      detector_ready <= 1'b1;
      overrun        <= 1'b0;
    end else begin
      trig_q  <= detector_trigger;
      trig_qq <= trig_q;
      en_q    <= enable;
      edge_q  <= raw_edge & detector_ready;
      if (edge_q) begin
        detector_ready <= 1'b0;
        bcnt           <= BUSY_M1;
      end else if (!detector_ready) begin
        if (bcnt == 32'd0) detector_ready <= 1'b1;
        else               bcnt <= bcnt - 32'd1;
      end
      if (raw_edge && !detector_ready) overrun <= 1'b1;
      else if (enable && !en_q)        overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_env_emulator.sv
// Directed bench for env_emulator with reduced timing parameters.
// Cycle c = interval after rising edge c; inputs set before edge c.
module tb_env_emulator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic trig = 1'b0;
  logic fg, st, rdy, ovr, done;

  int n_cmp = 0;
  int n_bad = 0;

  env_emulator #(
    .FG_PERIOD_CYC(100), .FG_OPEN_CYC(10), .FG_COUNT(3),
    .START_DELAY_CYC(250), .START_WIDTH_CYC(20), .BUSY_CYC(64)
  ) dut (
    .clock(clk), .reset(rst_n), .enable(enable),
    .detector_trigger(trig), .fg_signal(fg), .start_signal(st),
    .detector_ready(rdy), .overrun(ovr), .fg_done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    trig = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  function automatic logic fg_exp(int c);
    return (c >= 90 && c <= 99) || (c >= 190 && c <= 199) ||
           (c >= 290 && c <= 299);
  endfunction

  function automatic logic trig_prof(int s, int c);
    logic a;
    a = (c >= 10 && c < 20);
    if (s == 1) a = a || (c >= 40 && c < 50) || (c >= 75 && c < 80);
    if (s == 2) a = a || (c >= 75 && c < 80);
    return a;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b1;
    trig = 1'b1;
    step();
    step();
    n_cmp++;
    if (fg !== 1'b0) begin
      n_bad++; $display("FAIL rst_fg got %b want 0", fg);
    end
    n_cmp++;
    if (st !== 1'b0) begin
      n_bad++; $display("FAIL rst_start got %b want 0", st);
    end
    n_cmp++;
    if (rdy !== 1'b1) begin
      n_bad++; $display("FAIL rst_ready got %b want 1", rdy);
    end
    n_cmp++;
    if (ovr !== 1'b0) begin
      n_bad++; $display("FAIL rst_overrun got %b want 0", ovr);
    end
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++; $display("FAIL rst_done got %b want 0", done);
    end
  endtask

  task automatic test_fastgate();
    do_reset();
    enable = 1'b1;
    for (int c = 0; c <= 400; c++) begin
      step();
      n_cmp++;
      if (fg !== fg_exp(c)) begin
        n_bad++; $display("FAIL fg c=%0d got %b want %b", c, fg, fg_exp(c));
      end
      n_cmp++;
      if (st !== (c >= 250 && c <= 269)) begin
        n_bad++; $display("FAIL start c=%0d got %b", c, st);
      end
      n_cmp++;
      if (done !== (c >= 300)) begin
        n_bad++; $display("FAIL done c=%0d got %b", c, done);
      end
    end
    enable = 1'b0;
    step();
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++; $display("FAIL done_clear got %b want 0", done);
    end
    step();
    step();
    enable = 1'b1;
    for (int c = 0; c <= 300; c++) begin
      step();
      n_cmp++;
      if (st !== (c >= 250 && c <= 269)) begin
        n_bad++; $display("FAIL restart_start c=%0d got %b", c, st);
      end
      n_cmp++;
      if (fg !== fg_exp(c)) begin
        n_bad++; $display("FAIL restart_fg c=%0d got %b", c, fg);
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_enable_drop();
    logic e;
    do_reset();
    enable = 1'b1;
    for (int c = 0; c <= 300; c++) begin
      if (c == 196) enable = 1'b0;
      step();
      e = (c >= 90 && c <= 99) || (c >= 190 && c <= 195);
      n_cmp++;
      if (fg !== e) begin
        n_bad++; $display("FAIL drop_fg c=%0d got %b want %b", c, fg, e);
      end
      n_cmp++;
      if (st !== 1'b0 || done !== 1'b0) begin
        n_bad++; $display("FAIL drop_st_done c=%0d got %b%b want 00", c, st, done);
      end
    end
  endtask

  task automatic test_detector(input int s);
    logic eo;
    do_reset();
    for (int c = 0; c <= 150; c++) begin
      trig = trig_prof(s, c);
      step();
      eo = (s == 1) ? (c >= 41) : (s == 2) ? (c >= 76) : 1'b0;
      n_cmp++;
      if (rdy !== !(c >= 12 && c <= 75)) begin
        n_bad++; $display("FAIL ready s=%0d c=%0d got %b", s, c, rdy);
      end
      n_cmp++;
      if (ovr !== eo) begin
        n_bad++; $display("FAIL overrun s=%0d c=%0d got %b want %b", s, c, ovr, eo);
      end
    end
    if (s != 0) begin
      enable = 1'b1;
      step();
      n_cmp++;
      if (ovr !== 1'b0) begin
        n_bad++; $display("FAIL ovr_clear s=%0d got %b want 0", s, ovr);
      end
      enable = 1'b0;
    end
  endtask

  task automatic test_reset_busy();
    do_reset();
    for (int c = 0; c <= 42; c++) begin
      trig = trig_prof(0, c);
      step();
    end
    n_cmp++;
    if (rdy !== 1'b0) begin
      n_bad++; $display("FAIL busy_pre got %b want 0", rdy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (rdy !== 1'b1) begin
      n_bad++; $display("FAIL busy_async got %b want 1", rdy);
    end
    step();
    rst_n = 1'b1;
    for (int c = 0; c <= 100; c++) begin
      trig = trig_prof(0, c);
      step();
      n_cmp++;
      if (rdy !== !(c >= 12 && c <= 75)) begin
        n_bad++; $display("FAIL busy_restart c=%0d got %b", c, rdy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fastgate();
    test_enable_drop();
    test_detector(0);
    test_detector(1);
    test_detector(2);
    test_reset_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
